// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S receiver.
//   AUDIO_DW_DEF / SYNC_STAGES_DEF : default parameter values
//   LR_LEFT / LR_RIGHT             : LRCLK levels for each channel
//   CNT_W / cnt_sat_inc            : bit counter width and saturating increment
package i2s_pkg;

  localparam int unsigned AUDIO_DW_DEF    = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  localparam int unsigned      CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchroniser with registered rising-edge detect.
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous input
//   level        : synchronised level, aligned with rise
//   rise         : one-clk pulse when the synchronised level goes 0 -> 1
// level is taken one flop after the chain so that, across several instances,
// every level output and the rise pulse describe the same sampling instant.
module i2s_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver (Philips format, MSB first, one-bit delay after LRCLK).
//   clk, reset_n          : system clock (>= 4x SCLK), async active-low reset
//   sclk, lrclk, sdata    : asynchronous I2S inputs, sampled on SCLK rise
//   left_chan, right_chan : last complete stereo pair
//   valid                 : one-clk strobe when left_chan/right_chan update
//   locked                : a frame boundary has been seen since reset
//   frame_err             : sticky word-length error (only with I2S_RX_FRAME_ERR_EN)
// Build option: define I2S_RX_FRAME_ERR_EN to add the frame_err output.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned AUDIO_DW    = AUDIO_DW_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                valid,
`ifdef I2S_RX_FRAME_ERR_EN
  output logic                frame_err,
`endif
  output logic                locked
);

  logic sclk_rise, ws, sd;
  logic unused_sclk_level, unused_ws_rise, unused_sd_rise;

  // Three identical synchronisers keep sclk, lrclk and sdata mutually aligned.
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sclk),
    .level   (unused_sclk_level),
    .rise    (sclk_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (lrclk),
    .level   (ws),
    .rise    (unused_ws_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sdata),
    .level   (sd),
    .rise    (unused_sd_rise)
  );

  logic [AUDIO_DW-1:0] shreg, word, left_hold;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_inc;
  logic                ws_d, got_left, ws_change;

  // Shift register with the current bit merged in; bits past AUDIO_DW are dropped.
  always_comb begin
    word = shreg;
    for (int i = 0; i < AUDIO_DW; i++) begin
      if (bit_cnt == CNT_W'(AUDIO_DW - 1 - i)) word[i] = sd;
    end
  end

  assign bit_cnt_inc = cnt_sat_inc(bit_cnt);
  assign ws_change   = (ws != ws_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      ws_d       <= LR_LEFT;
      got_left   <= 1'b0;
      left_hold  <= '0;
      left_chan  <= '0;
      right_chan <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sclk_rise) begin
        ws_d <= ws;
        if (ws_change) begin
          // The bit sampled on the LRCLK-change rise is the LSB of channel ws_d.
          shreg   <= '0;
          bit_cnt <= '0;
          locked  <= 1'b1;
          if (ws_d == LR_LEFT) begin
            left_hold <= word;
            got_left  <= locked;  // words finished before lock are partial
          end else if (got_left) begin
            left_chan  <= left_hold;
            right_chan <= word;
            valid      <= 1'b1;
            got_left   <= 1'b0;
          end
        end else begin
          shreg   <= word;
          bit_cnt <= bit_cnt_inc;
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
    end else if (sclk_rise && ws_change && locked && (bit_cnt_inc != CNT_W'(AUDIO_DW))) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table-driven frames plus hand-written
// sequences for back-to-back frames, mid-word reset and 4:1 clocking.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          sdata = 1'b0;
  logic [DW-1:0] left_chan, right_chan;
  logic          valid, locked;
`ifdef I2S_RX_FRAME_ERR_EN
  logic          frame_err;
`endif

  i2s_rx #(.AUDIO_DW(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid      (valid),
`ifdef I2S_RX_FRAME_ERR_EN
    .frame_err  (frame_err),
`endif
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Posedge counter and boundary timestamp for latency measurement.
  int cyc   = 0;
  int cyc_b = 0;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  logic [DW-1:0] mon_l[$];
  logic [DW-1:0] mon_r[$];
  int            mon_lat[$];
  int            wide_err = 0;
  logic          valid_prev = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      mon_l.push_back(left_chan);
      mon_r.push_back(right_chan);
      mon_lat.push_back(cyc - cyc_b);
      if (valid_prev) wide_err++;
    end
    valid_prev = valid;
  end

  // I2S transmitter model: data lags LRCLK by one slot.
  int   half_ns = 40;
  logic prev_bit = 1'b0;
  logic prev_lr = 1'b0;

  task automatic slot(input logic lr, input logic d);
    sclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    #(half_ns);
    sclk = 1'b1;
    if (prev_lr == LR_RIGHT && lr == LR_LEFT) cyc_b = cyc;
    prev_lr = lr;
    #(half_ns);
  endtask

  task automatic send_word(input logic lr, input logic [63:0] val, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      slot(lr, prev_bit);
      prev_bit = val[nbits-1-i];
    end
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int nbits);
    send_word(LR_LEFT, l, nbits);
    send_word(LR_RIGHT, r, nbits);
  endtask

  // Closes the last right word, then parks SCLK low.
  task automatic flush();
    slot(LR_LEFT, prev_bit);
    prev_bit = 1'b0;
    slot(LR_LEFT, 1'b0);
    sclk = 1'b0;
    #(half_ns);
    repeat (8) @(posedge clk);
  endtask

  // Phase keeps SCLK edges off clk posedges (posedges sit at 5 mod 10 ns).
  task automatic start_stream(input int phase);
    @(posedge clk);
    #(phase);
    prev_bit = 1'b0;
    prev_lr  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sclk    = 1'b0;
    lrclk   = 1'b0;
    sdata   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_l.delete();
    mon_r.delete();
    mon_lat.delete();
  endtask

  function automatic logic [DW-1:0] q_at(input logic [DW-1:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 'x;
  endfunction

  typedef struct {
    logic [63:0] lval;
    logic [63:0] rval;
    int          nbits;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    logic        exp_ferr;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [31:0] xl, xr, yl, yr, rw;
    int          ph;

    tbl[0] = '{64'hA5A5_0001, 64'h5A5A_8000, 32, 32'hA5A5_0001, 32'h5A5A_8000, 1'b0};
    tbl[1] = '{64'h12_3456, 64'h65_4321, 24, 32'h1234_5600, 32'h6543_2100, 1'b1};
    tbl[2] = '{64'hDE_ADBE_EF11, 64'hCA_FEF0_0D22, 40, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1};
    tbl[3] = '{64'hFFFF_FFFF, 64'h0000_0000, 32, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[4] = '{64'h80, 64'h01, 8, 32'h8000_0000, 32'h0100_0000, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_left", 64'(left_chan), 64'h0);
    check("reset_right", 64'(right_chan), 64'h0);
    check("reset_valid", 64'(valid), 64'h0);
    check("reset_locked", 64'(locked), 64'h0);
`ifdef I2S_RX_FRAME_ERR_EN
    check("reset_frame_err", 64'(frame_err), 64'h0);
`endif

    // Table: each vector sends two frames; the first is discarded by lock-up.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      half_ns = 40;
      start_stream(3);
      send_frame(tbl[v].lval, tbl[v].rval, tbl[v].nbits);
      send_frame(tbl[v].lval, tbl[v].rval, tbl[v].nbits);
      flush();
      check($sformatf("vec%0d_count", v), 64'(mon_l.size()), 64'd1);
      check($sformatf("vec%0d_left", v), 64'(q_at(mon_l, 0)), 64'(tbl[v].exp_l));
      check($sformatf("vec%0d_right", v), 64'(q_at(mon_r, 0)), 64'(tbl[v].exp_r));
      check($sformatf("vec%0d_locked", v), 64'(locked), 64'h1);
`ifdef I2S_RX_FRAME_ERR_EN
      check($sformatf("vec%0d_frame_err", v), 64'(frame_err), 64'(tbl[v].exp_ferr));
`endif
    end

    // Ten back-to-back frames after one discarded lock-up frame.
    do_reset();
    half_ns = 40;
    start_stream(7);
    for (int i = 0; i <= 10; i++) begin
      send_frame(64'(32'h1111_0000 + 32'(i)), 64'(32'h2222_0000 + 32'(i * 3)), 32);
    end
    flush();
    check("b2b_count", 64'(mon_l.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("b2b_left%0d", k), 64'(q_at(mon_l, k)), 64'(32'h1111_0000 + 32'(k + 1)));
      check($sformatf("b2b_right%0d", k), 64'(q_at(mon_r, k)),
            64'(32'h2222_0000 + 32'((k + 1) * 3)));
    end
    check("b2b_pulse_width", 64'(wide_err), 64'd0);

    // Reset in the middle of a right word.
    do_reset();
    half_ns = 40;
    start_stream(4);
    send_frame(64'h0102_0304, 64'h0506_0708, 32);
    send_frame(64'h0102_0304, 64'h0506_0708, 32);
    send_word(LR_LEFT, 64'h0A0B_0C0D, 32);
    rw = 32'h7777_1234;
    for (int i = 0; i < 12; i++) begin
      slot(LR_RIGHT, prev_bit);
      prev_bit = rw[31-i];
    end
    check("pre_reset_locked", 64'(locked), 64'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_left", 64'(left_chan), 64'h0);
    check("midrst_right", 64'(right_chan), 64'h0);
    check("midrst_valid", 64'(valid), 64'h0);
    check("midrst_locked", 64'(locked), 64'h0);
    mon_l.delete();
    mon_r.delete();
    mon_lat.delete();
    #29;
    reset_n = 1'b1;
    for (int i = 12; i < 32; i++) begin
      slot(LR_RIGHT, prev_bit);
      prev_bit = rw[31-i];
    end
    xl = 32'h0BAD_F00D;
    xr = 32'h600D_CAFE;
    yl = 32'h1122_3344;
    yr = 32'h5566_7788;
    send_frame(64'(xl), 64'(xr), 32);
    send_frame(64'(yl), 64'(yr), 32);
    flush();
    check("midrst_count", 64'(mon_l.size()), 64'd2);
    check("midrst_first_left", 64'(q_at(mon_l, 0)), 64'(xl));
    check("midrst_first_right", 64'(q_at(mon_r, 0)), 64'(xr));
    check("midrst_second_left", 64'(q_at(mon_l, 1)), 64'(yl));
    check("midrst_second_right", 64'(q_at(mon_r, 1)), 64'(yr));

    // clk:sclk = 4:1 with a random SCLK phase; latency is SS+2 posedges.
    do_reset();
    half_ns = 20;
    ph = int'($urandom_range(1, 8));
    if (ph >= 5) ph++;
    start_stream(ph);
    for (int i = 0; i < 3; i++) send_frame(tbl[0].lval, tbl[0].rval, 32);
    flush();
    check("fast_count", 64'(mon_l.size()), 64'd2);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("fast_left%0d", k), 64'(q_at(mon_l, k)), 64'(tbl[0].exp_l));
      check($sformatf("fast_right%0d", k), 64'(q_at(mon_r, k)), 64'(tbl[0].exp_r));
      check($sformatf("fast_latency%0d", k),
            64'((k < mon_lat.size()) ? mon_lat[k] : -1), 64'(SS + 2));
    end
    check("fast_pulse_width", 64'(wide_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver, slave mode: accepts externally generated SCLK, LRCLK and SDATA and reconstructs parallel left/right samples in the `clk` domain.
- It is the receive-side counterpart of the card's I2S transmitter; it sits between an external codec/ADC serial output and the sample FIFO / mixer.
- All three serial inputs are asynchronous to `clk` and are synchronised internally.

Parameters:
- AUDIO_DW, 32, sample width in bits per channel (8..64).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (2..4).

Ports:
- clk  input  1  system clock; must be at least 4x SCLK; SCLK high and low phases each at least 2 clk periods.
- reset_n  input  1  asynchronous active-low reset.
- sclk  input  1  I2S bit clock, asynchronous.
- lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
- sdata  input  1  I2S serial data, asynchronous; MSB first.
- left_chan  output  AUDIO_DW  last complete left sample.
- right_chan  output  AUDIO_DW  last complete right sample.
- valid  output  1  one-clk strobe; left_chan/right_chan updated this cycle.
- locked  output  1  high once a frame boundary has been seen since reset.

Behaviour:
- Reset (async assert, sync release): left_chan=0, right_chan=0, valid=0, locked=0. Shift register, bit_cnt and ws_d are all 0; the got_left flag is cleared.
- Synchronisation: sclk, lrclk and sdata each pass through SYNC_STAGES flops.
  - All three share the same depth, so they stay mutually aligned.
  - sclk_rise = synced sclk is 1 and its previous value was 0. This is the only sample point; falling edges are ignored.
- Format: Philips I2S. The MSB arrives on the first SCLK rising edge after the one where a new LRCLK level is first sampled (one-bit delay).
- On each sclk_rise:
  - ws = synced lrclk. The current bit belongs to channel ws_d, the ws value sampled at the previous rise.
  - If bit_cnt < AUDIO_DW: shreg[AUDIO_DW-1-bit_cnt] <= sdata.
  - bit_cnt increments and saturates at 255.
  - If ws != ws_d, the word for channel ws_d completes, including the current bit:
    - word = shreg with the current bit merged in.
    - Channel 0 (left): left_hold <= word; got_left <= locked.
    - Channel 1 (right), with got_left=1: left_chan <= left_hold, right_chan <= word, valid=1 for exactly one clk, got_left <= 0.
    - In either case: shreg cleared, bit_cnt <= 0, locked <= 1.
  - ws_d <= ws.
- Words completed while locked=0 are discarded, so the partial first word is never output. A right word without a preceding left word since lock is also discarded.
- Word-length mismatch:
  - Fewer than AUDIO_DW bits: the LSBs stay 0 (MSB-justified).
  - More than AUDIO_DW bits: extra bits are dropped.
- Latency: valid rises SYNC_STAGES+2 clk cycles after the external SCLK rising edge that samples LRCLK low following a right word. left_chan/right_chan hold until the next valid.
- Missing SCLK: all state holds indefinitely; there is no timeout.
- Reset mid-word: all state is cleared; the receiver must re-lock on the next LRCLK transition.

Optional Feature:
- Macro I2S_RX_FRAME_ERR_EN.
- Defined: adds output port frame_err (1 bit, reset 0).
  - At each completed word with locked=1, frame_err <= 1 if the bit count including the current bit is not AUDIO_DW.
  - Sticky until reset_n.
  - The sample is still output.
- Undefined: no port, no logic; mismatched words are silently truncated or padded.

Decomposition:
- Shared package i2s_pkg: AUDIO_DW default constant, SYNC_STAGES default, LR_LEFT=0 / LR_RIGHT=1 constants.
- Sub-module i2s_sync_edge: parameterised N-stage synchroniser with rise-edge output.
  - Instantiated for sclk (edge used).
  - Also used for lrclk and sdata (level only), keeping the three paths at equal depth.

Test Plan:
- Reset release, then a 32-bit frame L=0xA5A5_0001, R=0x5A5A_8000 at clk:sclk = 8:1 -> first partial frame discarded. Next complete frame gives valid pulse width 1, left_chan=0xA5A5_0001, right_chan=0x5A5A_8000, locked=1.
- Ten back-to-back frames with incrementing samples -> exactly ten valid pulses, each pair matching, none dropped or duplicated.
- AUDIO_DW=32 with 24-bit transmitted words L=0x123456 -> left_chan=0x1234_5600. With the macro defined, frame_err=1.
- 40-bit transmitted words, first 32 bits 0xDEADBEEF -> left_chan=0xDEADBEEF, extra bits ignored.
- reset_n asserted mid-right-word -> outputs 0 immediately, locked=0. The next valid carries only a fully received post-reset frame.
- clk:sclk = 4:1 with random phase offset between sclk and clk -> identical samples to the 8:1 case; valid latency equals SYNC_STAGES+2 clk after the boundary SCLK edge.
